// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage load/store engine: access sizes,
// FSM states and the byte-lane strobe helper.
package mem_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    MSZ_B,
    MSZ_H,
    MSZ_W,
    MSZ_D
  } msize_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } memu_state_e;

  // (2^(2^size) - 1) << off, built wide then cut back to the 8 lanes.
  function automatic logic [7:0] strobe_of(msize_e size, logic [2:0] off);
    logic [15:0] m;
    m = ((16'd1 << (5'd1 << size)) - 16'd1) << off;
    return m[7:0];
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/ack data bus between the MEM stage and memory.
// master: dreq_* out, dresp_* in.  slave: the reverse.
interface mem_access_unit_if #(
  parameter int XLEN = 64
);

  logic            dreq_valid;
  logic            dreq_wen;
  logic [XLEN-1:0] dreq_addr;
  logic [1:0]      dreq_size;
  logic [7:0]      dreq_strobe;
  logic [XLEN-1:0] dreq_wdata;
  logic            dresp_data_ok;
  logic [XLEN-1:0] dresp_rdata;

  modport master (
    output dreq_valid, dreq_wen, dreq_addr,
    output dreq_size, dreq_strobe, dreq_wdata,
    input  dresp_data_ok, dresp_rdata
  );

  modport slave (
    input  dreq_valid, dreq_wen, dreq_addr,
    input  dreq_size, dreq_strobe, dreq_wdata,
    output dresp_data_ok, dresp_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store shift/strobe and load shift/extend.
// st_*: size/off/wr/data -> strobe/data.  ld_*: size/off/unsigned/raw -> data.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  msize_e          st_size_i,
  input  logic [2:0]      st_off_i,
  input  logic            st_wr_i,
  input  logic [XLEN-1:0] st_data_i,
  output logic [7:0]      st_strobe_o,
  output logic [XLEN-1:0] st_data_o,
  input  msize_e          ld_size_i,
  input  logic [2:0]      ld_off_i,
  input  logic            ld_unsigned_i,
  input  logic [XLEN-1:0] ld_raw_i,
  output logic [XLEN-1:0] ld_data_o
);

  logic [XLEN-1:0] sh;
  logic            sx;

  assign st_strobe_o = st_wr_i ? strobe_of(st_size_i, st_off_i) : 8'd0;
  assign st_data_o   = st_data_i << {st_off_i, 3'b000};

  // Bytes shifted in from past lane 7 are zero, so a
  // lane-crossing load sees 0 in its upper bytes.
  assign sh = ld_raw_i >> {ld_off_i, 3'b000};

  always_comb begin
    sx        = 1'b0;
    ld_data_o = sh;
    unique case (ld_size_i)
      MSZ_B: begin
        sx        = ~ld_unsigned_i & sh[7];
        ld_data_o = {{(XLEN-8){sx}}, sh[7:0]};
      end
      MSZ_H: begin
        sx        = ~ld_unsigned_i & sh[15];
        ld_data_o = {{(XLEN-16){sx}}, sh[15:0]};
      end
      MSZ_W: begin
        sx        = ~ld_unsigned_i & sh[31];
        ld_data_o = {{(XLEN-32){sx}}, sh[31:0]};
      end
      MSZ_D: ld_data_o = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: runs the EXE_MEM access on the data bus,
// stalls the pipe until ack, returns extended load data.
// Ports: clk, rst_n (sync, active-low), mem_* access, hold, bus (master),
// stallreq_from_memu, ld_data, ld_valid; misalign_o only with
// MEMU_MISALIGN_TRAP_EN defined (misaligned accesses skip the bus).
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_valid,
  input  logic            mem_rd,
  input  logic            mem_wr,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic            hold,
  mem_access_unit_if.master bus,
  output logic            stallreq_from_memu,
  output logic [XLEN-1:0] ld_data,
  output logic            ld_valid
`ifdef MEMU_MISALIGN_TRAP_EN
  ,
  output logic            misalign_o
`endif
);

  memu_state_e     state_q;
  logic            dreq_valid_q;
  logic            wen_q;
  logic [XLEN-1:0] addr_q;
  logic [1:0]      size_q;
  logic [7:0]      strobe_q;
  logic [XLEN-1:0] wdata_q;
  logic            rd_q;
  logic            uns_q;
  logic [XLEN-1:0] ld_data_q;
  logic            ld_valid_q;

  logic            acc;
  logic            trap;
  logic [7:0]      st_strobe;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] ld_ext;

  assign acc = mem_valid & (mem_rd | mem_wr);
  assign stallreq_from_memu = acc & (state_q != DONE);

`ifdef MEMU_MISALIGN_TRAP_EN
  logic mis_q;

  always_comb begin
    trap = 1'b0;
    unique case (1'b1)
      mem_size == 2'd1: trap = mem_addr[0];
      mem_size == 2'd2: trap = |mem_addr[1:0];
      mem_size == 2'd3: trap = |mem_addr[2:0];
      default:          trap = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else if (state_q == IDLE && acc && trap) begin
      mis_q <= 1'b1;
    end else if (state_q == DONE && !hold) begin
      mis_q <= 1'b0;
    end
  end

  assign misalign_o = mis_q;
`else
  assign trap = 1'b0;
`endif

  mem_lane_align #(
    .XLEN (XLEN)
  ) u_align (
    .st_size_i     (msize_e'(mem_size)),
    .st_off_i      (mem_addr[2:0]),
    .st_wr_i       (mem_wr),
    .st_data_i     (mem_wdata),
    .st_strobe_o   (st_strobe),
    .st_data_o     (st_wdata),
    .ld_size_i     (msize_e'(size_q)),
    .ld_off_i      (addr_q[2:0]),
    .ld_unsigned_i (uns_q),
    .ld_raw_i      (bus.dresp_rdata),
    .ld_data_o     (ld_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dreq_valid_q <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      size_q       <= 2'd0;
      strobe_q     <= 8'd0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      uns_q        <= 1'b0;
      ld_data_q    <= '0;
      ld_valid_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc && trap) begin
            state_q <= DONE;
          end else if (acc) begin
            state_q      <= BUSY;
            dreq_valid_q <= 1'b1;
            wen_q        <= mem_wr;
            addr_q       <= mem_addr;
            size_q       <= mem_size;
            strobe_q     <= st_strobe;
            wdata_q      <= st_wdata;
            rd_q         <= mem_rd;
            uns_q        <= mem_unsigned;
          end
        end
        BUSY: begin
          if (bus.dresp_data_ok) begin
            state_q      <= DONE;
            dreq_valid_q <= 1'b0;
            ld_valid_q   <= rd_q;
            ld_data_q    <= rd_q ? ld_ext : '0;
          end
        end
        DONE: begin
          // Held instruction must not be reissued.
          if (!hold) begin
            state_q    <= IDLE;
            ld_valid_q <= 1'b0;
            ld_data_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dreq_valid  = dreq_valid_q;
  assign bus.dreq_wen    = wen_q;
  assign bus.dreq_addr   = addr_q;
  assign bus.dreq_size   = size_q;
  assign bus.dreq_strobe = strobe_q;
  assign bus.dreq_wdata  = wdata_q;
  assign ld_data         = ld_data_q;
  assign ld_valid        = ld_valid_q;

  a_no_flush_in_busy: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == BUSY) |-> mem_valid
  );

  a_rd_wr_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(mem_valid & mem_rd & mem_wr)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed accesses,
// byte-level reference model, per-cycle bus/load compare.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, mem_valid, mem_rd, mem_wr, mem_unsigned, hold;
  logic [1:0]  mem_size;
  logic [63:0] mem_addr, mem_wdata, ld_data;
  logic        stall, ld_valid;
`ifdef MEMU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  mem_access_unit_if #(.XLEN(64)) bus ();

  mem_access_unit #(.XLEN(64)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .mem_valid          (mem_valid),
    .mem_rd             (mem_rd),
    .mem_wr             (mem_wr),
    .mem_size           (mem_size),
    .mem_unsigned       (mem_unsigned),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .hold               (hold),
    .bus                (bus),
    .stallreq_from_memu (stall),
    .ld_data            (ld_data),
    .ld_valid           (ld_valid)
`ifdef MEMU_MISALIGN_TRAP_EN
    ,
    .misalign_o         (misalign)
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic        m_rd, m_wr, m_uns;
  logic [1:0]  m_sz;
  logic [63:0] m_addr, m_wd, m_rdw;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chki(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference model, byte by byte.
  function automatic bit m_mis(logic [1:0] sz, logic [63:0] a);
`ifdef MEMU_MISALIGN_TRAP_EN
    int n;
    n = 1 << sz;
    return (int'(a[2:0]) % n) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] m_strobe(logic [1:0] sz, logic wr,
                                          logic [63:0] a);
    logic [7:0] s;
    int n, off;
    s = 8'd0;
    n = 1 << sz;
    off = int'(a[2:0]);
    for (int i = 0; i < 8; i++)
      if (wr && i >= off && i < off + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(logic [63:0] a, logic [63:0] wd);
    logic [63:0] r;
    int off;
    r = 64'd0;
    off = int'(a[2:0]);
    for (int i = 0; i < 8; i++)
      if (i >= off) r[8*i +: 8] = wd[8*(i-off) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(logic [1:0] sz, logic uns,
                                         logic [63:0] a, logic [63:0] w);
    logic [63:0] r;
    int n, off;
    r = 64'd0;
    n = 1 << sz;
    off = int'(a[2:0]);
    for (int k = 0; k < 8; k++)
      if (k < n && off + k < 8) r[8*k +: 8] = w[8*(off+k) +: 8];
    if (!uns && n < 8 && r[8*n-1])
      for (int k = 0; k < 8; k++)
        if (k >= n) r[8*k +: 8] = 8'hFF;
    return r;
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      if (bus.dreq_valid) begin
        chk("req_addr", bus.dreq_addr, m_addr);
        chk("req_wen", 64'(bus.dreq_wen), 64'(m_wr));
        chk("req_size", 64'(bus.dreq_size), 64'(m_sz));
        chk("req_strobe", 64'(bus.dreq_strobe),
            64'(m_strobe(m_sz, m_wr, m_addr)));
        if (m_wr) chk("req_wdata", bus.dreq_wdata, m_wdata(m_addr, m_wd));
      end
      if (ld_valid) chk("ld_data", ld_data, m_load(m_sz, m_uns, m_addr, m_rdw));
      else          chk("ld_zero", ld_data, 64'd0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the access retires.
  task automatic access(
    input  logic        rd, wr,
    input  logic [1:0]  sz,
    input  logic        uns,
    input  logic [63:0] a, wd, rw,
    input  int          wt, hd,
    output int          stc, pul, ldc,
    output logic [7:0]  cstb,
    output logic [63:0] cwd, cld,
    output logic        cwen
  );
    int  busy, hcnt;
    bit  fin, prev_v, mis;
    m_rd = rd; m_wr = wr; m_sz = sz; m_uns = uns;
    m_addr = a; m_wd = wd; m_rdw = rw;
    mis = m_mis(sz, a);
    mem_valid = 1'b1; mem_rd = rd; mem_wr = wr; mem_size = sz;
    mem_unsigned = uns; mem_addr = a; mem_wdata = wd;
    bus.dresp_rdata = rw;
    stc = 0; pul = 0; ldc = 0; busy = 0; hcnt = 0;
    fin = 1'b0; prev_v = 1'b0;
    cstb = 8'd0; cwd = 64'd0; cld = 64'd0; cwen = 1'b0;
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("stall_same_cycle", 64'(stall), 64'd1);
      if (stall) stc++;
      if (bus.dreq_valid && !prev_v) pul++;
      prev_v = bus.dreq_valid;
      if (ld_valid) ldc++;
      bus.dresp_data_ok = 1'b0;
      if (bus.dreq_valid) begin
        if (busy == 0) begin
          cstb = bus.dreq_strobe;
          cwd  = bus.dreq_wdata;
          cwen = bus.dreq_wen;
        end
        if (busy == wt) bus.dresp_data_ok = 1'b1;
        busy++;
      end
      if (!stall && cyc > 0) begin
        if (hcnt == 0) cld = ld_data;
`ifdef MEMU_MISALIGN_TRAP_EN
        chk("misalign_o", 64'(misalign), 64'(mis));
`endif
        // A stray ack while held must be ignored.
        if (hcnt < hd) begin
          hold = 1'b1;
          bus.dresp_data_ok = 1'b1;
          hcnt++;
        end else begin
          hold = 1'b0;
          fin = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    hold = 1'b0;
    bus.dresp_data_ok = 1'b0;
    if (!fin) begin
      n_chk++;
      n_err++;
      $display("FAIL access_timeout: addr %h never retired", a);
    end
    chki("stall_cycles", stc, mis ? 1 : 2 + wt);
    chki("req_pulses", pul, mis ? 0 : 1);
    chki("ldv_cycles", ldc, (rd && !mis) ? 1 + hd : 0);
  endtask

  int          stc, pul, ldc;
  logic [7:0]  cstb;
  logic [63:0] cwd, cld;
  logic        cwen;

  initial begin
    rst_n = 1'b0; mem_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_size = 2'd0; mem_unsigned = 1'b0; mem_addr = 64'd0;
    mem_wdata = 64'd0; hold = 1'b0;
    bus.dresp_data_ok = 1'b0; bus.dresp_rdata = 64'd0;
    m_rd = 1'b0; m_wr = 1'b0; m_uns = 1'b0; m_sz = 2'd0;
    m_addr = 64'd0; m_wd = 64'd0; m_rdw = 64'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dreq_valid", 64'(bus.dreq_valid), 64'd0);
    chk("rst_strobe", 64'(bus.dreq_strobe), 64'd0);
    chk("rst_addr", bus.dreq_addr, 64'd0);
    chk("rst_ld_valid", 64'(ld_valid), 64'd0);
    chk("rst_ld_data", ld_data, 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // ld 0x1000, ack on 3rd BUSY cycle.
    access(1'b1, 1'b0, 2'd3, 1'b0, 64'h1000, 64'd0,
           64'h8877665544332211, 2, 0, stc, pul, ldc, cstb, cwd, cld, cwen);
    chki("t1_stall4", stc, 4);
    chk("t1_ld", cld, 64'h8877665544332211);
    chki("t1_ldv1", ldc, 1);

    // lb / lbu at top lane.
    access(1'b1, 1'b0, 2'd0, 1'b0, 64'h1007, 64'd0,
           64'h80FFEEDDCCBBAA99, 0, 0, stc, pul, ldc, cstb, cwd, cld, cwen);
    chk("lb_sext", cld, 64'hFFFFFFFFFFFFFF80);
    chki("lb_stall2", stc, 2);
    access(1'b1, 1'b0, 2'd0, 1'b1, 64'h1007, 64'd0,
           64'h80FFEEDDCCBBAA99, 0, 0, stc, pul, ldc, cstb, cwd, cld, cwen);
    chk("lbu_zext", cld, 64'h80);

    // sh 0x1002.
    access(1'b0, 1'b1, 2'd1, 1'b0, 64'h1002, 64'hBEEF,
           64'd0, 1, 0, stc, pul, ldc, cstb, cwd, cld, cwen);
    chk("sh_strobe", 64'(cstb), 64'h0C);
    chk("sh_wdata", cwd, 64'h00000000BEEF0000);
    chk("sh_wen", 64'(cwen), 64'd1);

    // Back-to-back lw then sw, immediate ack.
    access(1'b1, 1'b0, 2'd2, 1'b0, 64'h2004, 64'd0,
           64'hDEADBEEF12345678, 0, 0, stc, pul, ldc, cstb, cwd, cld, cwen);
    chk("lw_sext", cld, 64'hFFFFFFFFDEADBEEF);
    access(1'b0, 1'b1, 2'd2, 1'b0, 64'h2008, 64'hCAFEF00D,
           64'd0, 0, 0, stc, pul, ldc, cstb, cwd, cld, cwen);
    chk("sw_strobe", 64'(cstb), 64'h0F);
    chk("sw_wdata", cwd, 64'h00000000CAFEF00D);

    // lh held 3 extra cycles in DONE.
    access(1'b1, 1'b0, 2'd1, 1'b0, 64'h3006, 64'd0,
           64'h7FFF000000000000, 0, 3, stc, pul, ldc, cstb, cwd, cld, cwen);
    chk("lh_pos", cld, 64'h7FFF);
    chki("hold_ldv4", ldc, 4);

    // sd full lanes.
    access(1'b0, 1'b1, 2'd3, 1'b0, 64'h3000, 64'h0123456789ABCDEF,
           64'd0, 0, 0, stc, pul, ldc, cstb, cwd, cld, cwen);
    chk("sd_strobe", 64'(cstb), 64'hFF);

`ifndef MEMU_MISALIGN_TRAP_EN
    // Lane-crossing accesses lose the bytes past lane 7.
    access(1'b0, 1'b1, 2'd2, 1'b0, 64'h3006, 64'h11223344,
           64'd0, 0, 0, stc, pul, ldc, cstb, cwd, cld, cwen);
    chk("sw_x_strobe", 64'(cstb), 64'hC0);
    chk("sw_x_wdata", cwd, 64'h3344000000000000);
    access(1'b1, 1'b0, 2'd2, 1'b0, 64'h4006, 64'd0,
           64'h8001000000000000, 1, 0, stc, pul, ldc, cstb, cwd, cld, cwen);
    chk("lw_x_ld", cld, 64'h0000000000008001);
`else
    access(1'b1, 1'b0, 2'd2, 1'b0, 64'h1002, 64'd0,
           64'h1111111111111111, 0, 0, stc, pul, ldc, cstb, cwd, cld, cwen);
    chki("mis_no_req", pul, 0);
    chk("mis_ld_zero", cld, 64'd0);
`endif

    // Idle with a stray ack: no request, no stall.
    mem_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    bus.dresp_data_ok = 1'b1;
    @(negedge clk);
    chk("idle_stall", 64'(stall), 64'd0);
    chk("idle_req", 64'(bus.dreq_valid), 64'd0);
    @(posedge clk);
    #1;
    bus.dresp_data_ok = 1'b0;
    @(negedge clk);
    chk("idle_ack_ignored", 64'(bus.dreq_valid), 64'd0);
    @(posedge clk);
    #1;

    // Reset while BUSY.
    m_rd = 1'b1; m_wr = 1'b0; m_sz = 2'd3; m_uns = 1'b0;
    m_addr = 64'h5000; m_rdw = 64'd0;
    mem_valid = 1'b1; mem_rd = 1'b1; mem_size = 2'd3; mem_addr = 64'h5000;
    @(negedge clk);
    @(negedge clk);
    chk("busy_req_up", 64'(bus.dreq_valid), 64'd1);
    rst_n = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk);
    chk("rst_busy_req", 64'(bus.dreq_valid), 64'd0);
    chk("rst_busy_stall", 64'(stall), 64'd0);
    chk("rst_busy_ldv", 64'(ld_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req", 64'(bus.dreq_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
